// File: rtl/xy_point_loader.sv
// Receives a framed point list over the pin byte interface and stores it in the
// back bank of a double-buffered point RAM, swapping banks only on frame_sync.
module xy_point_loader #(
    parameter int          DEPTH     = 16,
    parameter int          AW        = 4,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    din,
    input  logic          din_strobe,
    input  logic          frame_sync,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_x,
    output logic [7:0]    rd_y,
    output logic [AW:0]   point_count,
    output logic          busy,
    output logic          swap_pending,
    output logic          frame_done,
    output logic          err
);

    typedef enum logic [1:0] {S_IDLE, S_LEN, S_PX, S_PY} state_t;

    localparam logic [8:0] DEPTH_W = 9'(DEPTH);

    state_t        state_q, state_d;
    logic          sync1_q, sync2_q, sync3_q;
    logic          front_sel_q, front_sel_d;
    logic [AW:0]   n_q, n_d;
    logic [AW:0]   point_count_q, point_count_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [7:0]    x_hold_q, x_hold_d;
    logic          swap_pending_q, swap_pending_d;
    logic          frame_done_q, frame_done_d;
    logic          err_q, err_d;
    logic [15:0]   rd_data_q;

    logic          accept;
    logic          len_ok;
    logic          wr_en;
    logic [AW:0]   wr_addr;

    // Bank-select bit is the address MSB: {bank, index}.
    logic [15:0]   mem [0:2*DEPTH-1];

    assign accept = sync2_q & ~sync3_q;
    assign len_ok = (din != 8'd0) && ({1'b0, din} <= DEPTH_W);

    always_comb begin
        state_d        = state_q;
        front_sel_d    = front_sel_q;
        n_d            = n_q;
        point_count_d  = point_count_q;
        wr_ptr_d       = wr_ptr_q;
        x_hold_d       = x_hold_q;
        swap_pending_d = swap_pending_q;
        frame_done_d   = 1'b0;
        err_d          = 1'b0;
        wr_en          = 1'b0;
        wr_addr        = {~front_sel_q, wr_ptr_q};

        if (accept) begin
            if (swap_pending_q) begin
                // Back bank still awaiting display: drop the byte.
                err_d   = 1'b1;
                state_d = S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (din == SYNC_BYTE) state_d = S_LEN;
                    end
                    S_LEN: begin
                        if (len_ok) begin
                            n_d      = (AW+1)'(din);
                            wr_ptr_d = '0;
                            state_d  = S_PX;
                        end else begin
                            err_d   = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                    S_PX: begin
                        x_hold_d = din;
                        state_d  = S_PY;
                    end
                    S_PY: begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        if (({1'b0, wr_ptr_q} + (AW+1)'(1)) == n_q) begin
                            swap_pending_d = 1'b1;
                            state_d        = S_IDLE;
                        end else begin
                            state_d = S_PX;
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end

        if (swap_pending_q && frame_sync) begin
            front_sel_d    = ~front_sel_q;
            point_count_d  = n_q;
            swap_pending_d = 1'b0;
            frame_done_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            sync1_q        <= 1'b0;
            sync2_q        <= 1'b0;
            sync3_q        <= 1'b0;
            front_sel_q    <= 1'b0;
            n_q            <= '0;
            point_count_q  <= '0;
            wr_ptr_q       <= '0;
            x_hold_q       <= '0;
            swap_pending_q <= 1'b0;
            frame_done_q   <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            sync1_q        <= din_strobe;
            sync2_q        <= sync1_q;
            sync3_q        <= sync2_q;
            front_sel_q    <= front_sel_d;
            n_q            <= n_d;
            point_count_q  <= point_count_d;
            wr_ptr_q       <= wr_ptr_d;
            x_hold_q       <= x_hold_d;
            swap_pending_q <= swap_pending_d;
            frame_done_q   <= frame_done_d;
            err_q          <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= {x_hold_q, din};
    end

    always_ff @(posedge clk) begin
        if (reset) rd_data_q <= '0;
        else       rd_data_q <= mem[{front_sel_q, rd_addr}];
    end

    assign rd_x         = rd_data_q[15:8];
    assign rd_y         = rd_data_q[7:0];
    assign point_count  = point_count_q;
    assign busy         = (state_q != S_IDLE);
    assign swap_pending = swap_pending_q;
    assign frame_done   = frame_done_q;
    assign err          = err_q;

endmodule

// File: doc/xy_point_loader.md
Name: xy_point_loader

Overview:
- Write-side companion to the XY vector wave generator: receives a point list over the pin byte interface and stores it in a double-buffered point RAM.
- The generator reads the front bank. The loader fills the back bank and swaps banks only at a generator frame boundary, so the display never tears.
- Sits between ui_in/uio_in pins and the image wave generator inside the top-level wrapper.

Parameters:
- DEPTH, 16, points per bank (power of two, ≥2)
- AW, 4, log2(DEPTH); address width
- SYNC_BYTE, 8'hA5, frame header byte

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- din  in  8  host data byte (pins, asynchronous to clk)
- din_strobe  in  1  host byte strobe (pin, asynchronous); rising edge marks a new byte
- frame_sync  in  1  generator frame boundary pulse (1 cycle, clk domain)
- rd_addr  in  AW  generator read address into the front bank
- rd_x  out  8  front-bank X at rd_addr, registered
- rd_y  out  8  front-bank Y at rd_addr, registered
- point_count  out  AW+1  valid points in the front bank (0..DEPTH)
- busy  out  1  high while a frame is being received (state not IDLE)
- swap_pending  out  1  back bank complete, waiting for frame_sync
- frame_done  out  1  1-cycle pulse when a swap occurs
- err  out  1  1-cycle pulse on protocol error or overrun

Behaviour:
- Strobe input: din_strobe passes through a 2-FF synchronizer plus an edge register. A byte is accepted on the cycle a synchronized 0→1 edge is seen (3 clk after the pin rises); din is sampled that same cycle.
- Host contract: din stable from strobe rise until ≥4 clk later; strobe high ≥4 clk and low ≥4 clk.
- Reset values: state=IDLE, front_sel=0, point_count=0, swap_pending=0, busy=0, frame_done=0, err=0, rd_x=0, rd_y=0, synchronizer flops=0. RAM contents are not reset.
- FSM states: IDLE, LEN, PX, PY. Transitions below happen only on byte-accept cycles.
  - IDLE: byte==SYNC_BYTE → LEN. Any other byte is ignored silently.
  - LEN: N=byte. If 1≤N≤DEPTH: latch N, wr_ptr=0, go to PX. Otherwise pulse err and go to IDLE.
  - PX: hold byte as x_hold, go to PY.
  - PY: write {x_hold, byte} to back[wr_ptr] and increment wr_ptr.
    - If wr_ptr+1==N: set swap_pending, go to IDLE.
    - Otherwise go to PX.
- Overrun: while swap_pending=1, every accepted byte is dropped and pulses err. The FSM stays in IDLE. busy=0 while pending.
- Swap: on any cycle with swap_pending=1 and frame_sync=1, in the same clock edge:
  - front_sel toggles
  - point_count ← latched N
  - swap_pending ← 0
  - frame_done pulses
  - Earliest swap is the cycle after the final Y byte is accepted. A frame_sync on the final-Y accept cycle itself does not swap.
  - frame_sync with swap_pending=0 has no effect.
- Read port:
  - rd_x/rd_y ← front[rd_addr], 1-cycle latency.
  - The cycle after a swap, reads come from the new front bank.
  - No range check against point_count; the generator must keep rd_addr < point_count and hold its output when point_count=0.
- Writes never touch the front bank. A frame that is shorter than the previous one leaves stale entries above N in the back bank; this is harmless because point_count bounds reads.
- Reset mid-frame: partial frame discarded, FSM to IDLE, and point_count=0 blanks the display.
- Per-byte FSM width math: wr_ptr is AW bits. N compare uses AW+1 bits so N=DEPTH is legal.

Test Plan:
- Basic load: after reset send A5,02,10,20,30,40, then pulse frame_sync → frame_done pulse, point_count=2. rd_addr=0 gives rd_x=10,rd_y=20 next cycle; rd_addr=1 gives 30,40.
- Tear-free swap: with frame 1 live, load a 3-point frame without frame_sync → swap_pending=1; rd outputs still return frame-1 data. After frame_sync: point_count=3 and new data is read.
- Length errors: send A5,00 → err pulse, FSM in IDLE. Send A5,11 (DEPTH=16) → err pulse. A following valid frame loads correctly.
- Overrun: while swap_pending=1 send A5 → err pulse, no state change. After frame_sync the display shows the pending frame.
- Full depth: send A5,10 (16 points, X=i, Y=255-i) → all 16 entries read back correctly, point_count=16.
- Reset mid-frame: reset after A5,04,11 → point_count=0, busy=0, rd_x=rd_y=0. Then send A5,01,55,66 + frame_sync → reads 55,66.
